weight_fetch_sequencer: RTL

- Read-side initiator for the weight memory. Walks every weight address in order and issues enable/address reads.
- Captures each returned SIMD weight word and presents it downstream on a valid/ready stream.
- Sits between layer control (start/done) and the matrix-vector SIMD datapath.
- Memory reads have fixed 1-cycle latency and no stall, so flow control is credit-based with a small buffer.

---
 rtl/weight_fetch_sequencer_pkg.sv | 21 ++
 rtl/weight_fetch_sequencer_if.sv | 28 ++
 rtl/weight_fetch_sequencer_fifo.sv | 72 +++++++
 rtl/weight_fetch_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/weight_fetch_sequencer_pkg.sv
// Shared types and constants for the weight fetch sequencer.
// Optional protocol checker is enabled with WEIGHT_FETCH_PROTOCOL_CHECK_EN.
package weight_fetch_sequencer_pkg;

   localparam int unsigned SIMD_WIDTH    = 32;
   localparam int unsigned WEIGHT_LEVELS = 2;
   localparam int unsigned WORD_WIDTH    = SIMD_WIDTH * WEIGHT_LEVELS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_e;

   function automatic int unsigned total_words(input int unsigned synapse_fold,
                                               input int unsigned output_channels);
      return synapse_fold * output_channels;
   endfunction

endpackage

// File: rtl/weight_fetch_sequencer_if.sv
// Weight-memory read port and downstream weight stream of the fetch sequencer.
interface weight_fetch_sequencer_if
   import weight_fetch_sequencer_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 12,
   parameter int unsigned WORD_WIDTH    = weight_fetch_sequencer_pkg::WORD_WIDTH
);

   logic                     mem_enable;
   logic [ADDRESS_WIDTH-1:0] mem_address;
   logic [WORD_WIDTH-1:0]    mem_read_data;
   logic                     mem_read_ready;
   logic [WORD_WIDTH-1:0]    w_data;
   logic                     w_valid;
   logic                     w_ready;
   logic                     w_last;

   modport master (
      output mem_enable, mem_address, w_data, w_valid, w_last,
      input  mem_read_data, mem_read_ready, w_ready
   );

   modport slave (
      input  mem_enable, mem_address, w_data, w_valid, w_last,
      output mem_read_data, mem_read_ready, w_ready
   );

endinterface

// File: rtl/weight_fetch_sequencer_fifo.sv
// First-word-fall-through FIFO buffering returned weight words plus their last-tag.
module weight_fetch_fifo
   import weight_fetch_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 65,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] storage_q [DEPTH];
   logic [WIDTH-1:0] storage_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full;
   logic             push_en;
   logic             pop_en;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign count    = count_q;
   assign pop_en   = pop && !empty;
   assign push_en  = push && (!full || pop_en);
   // Outputs stay at zero while empty so stale storage never leaks downstream.
   assign pop_data = empty ? '0 : storage_q[rd_ptr_q];

   always_comb begin
      storage_d = storage_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push_en) begin
         storage_d[wr_ptr_q] = push_data;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      storage_q <= storage_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Weight fetch sequencer: sweeps the weight memory num_passes times and streams words out.
// Define WEIGHT_FETCH_PROTOCOL_CHECK_EN to add the sticky proto_error output.
module weight_fetch_sequencer
   import weight_fetch_sequencer_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH   = 12,
   parameter int unsigned SYNAPSE_FOLD    = 18,
   parameter int unsigned SIMD_WIDTH      = weight_fetch_sequencer_pkg::SIMD_WIDTH,
   parameter int unsigned WEIGHT_LEVELS   = weight_fetch_sequencer_pkg::WEIGHT_LEVELS,
   parameter int unsigned OUTPUT_CHANNELS = 1,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned PASS_WIDTH      = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [PASS_WIDTH-1:0] num_passes,
   output logic                  busy,
   output logic                  done,
`ifdef WEIGHT_FETCH_PROTOCOL_CHECK_EN
   output logic                  proto_error,
`endif
   weight_fetch_sequencer_if.master bus
);

   localparam int unsigned WORD_W = SIMD_WIDTH * WEIGHT_LEVELS;
   localparam int unsigned TOTAL  = total_words(SYNAPSE_FOLD, OUTPUT_CHANNELS);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR    = ADDRESS_WIDTH'(TOTAL - 1);
   localparam logic [CNT_W:0]           DEPTH_CREDIT = (CNT_W + 1)'(FIFO_DEPTH);

   fetch_state_e            state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [PASS_WIDTH-1:0]   pass_q, pass_d;
   logic [PASS_WIDTH-1:0]   passes_q, passes_d;
   logic [CNT_W-1:0]        inflight_q, inflight_d;
   logic                    last_tag_q, last_tag_d;

   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_empty;
   logic [WORD_W:0]         fifo_pop_data;
   logic [CNT_W:0]          credit;
   logic                    issue;
   logic                    resp_ok;
   logic                    pop;
   logic                    at_last;

   // Every word either in flight or buffered holds one FIFO slot in reserve.
   assign credit  = {1'b0, fifo_count} + {1'b0, inflight_q};
   assign issue   = (state_q == FETCH) && (credit < DEPTH_CREDIT);
   assign resp_ok = bus.mem_read_ready && (inflight_q != '0);
   assign pop     = !fifo_empty && bus.w_ready;
   assign at_last = (addr_q == LAST_ADDR);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      pass_d     = pass_q;
      passes_d   = passes_q;
      inflight_d = inflight_q;
      last_tag_d = issue && at_last;
      done_d     = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (start) begin
               passes_d = num_passes;
               addr_d   = '0;
               pass_d   = '0;
               state_d  = (num_passes == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (issue) begin
               if (at_last) begin
                  addr_d = '0;
                  pass_d = pass_q + PASS_WIDTH'(1);
                  if (pass_q == passes_q - PASS_WIDTH'(1)) begin
                     state_d = DRAIN;
                  end
               end else begin
                  addr_d = addr_q + ADDRESS_WIDTH'(1);
               end
            end
         end
         DRAIN: begin
            if ((inflight_q == '0) && fifo_empty) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == FETCH) || (state_d == DRAIN);

      case ({issue, resp_ok})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         pass_q     <= '0;
         passes_q   <= '0;
         inflight_q <= '0;
         last_tag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         addr_q     <= addr_d;
         pass_q     <= pass_d;
         passes_q   <= passes_d;
         inflight_q <= inflight_d;
         last_tag_q <= last_tag_d;
      end
   end

   weight_fetch_fifo #(
      .WIDTH (WORD_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (resp_ok),
      .push_data ({last_tag_q, bus.mem_read_data}),
      .pop       (pop),
      .pop_data  (fifo_pop_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign busy            = busy_q;
   assign done            = done_q;
   assign bus.mem_enable  = issue;
   assign bus.mem_address = addr_q;
   assign bus.w_valid     = !fifo_empty;
   assign bus.w_data      = fifo_pop_data[WORD_W-1:0];
   assign bus.w_last      = fifo_pop_data[WORD_W];

`ifdef WEIGHT_FETCH_PROTOCOL_CHECK_EN
   logic proto_error_q, proto_error_d;

   always_comb begin
      proto_error_d = proto_error_q
                    | (bus.mem_read_ready && (inflight_q == '0))
                    | (resp_ok && (fifo_count == CNT_W'(FIFO_DEPTH)))
                    | (start && busy_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         proto_error_q <= 1'b0;
      end else begin
         proto_error_q <= proto_error_d;
      end
   end

   assign proto_error = proto_error_q;
`endif

endmodule
